key_matrix_scan: RTL and testbench
==================================

# key_matrix_scan

Scanner for the 4x4 front-panel key matrix, the input-side counterpart of the row-scanned 8x8 LED dot-matrix driver. It drives one matrix row low at a time, samples the active-low column lines, debounces whole-matrix snapshots and reports a single key press as a 4-bit code with a one-cycle valid strobe. It runs from the same 1 kHz scan clock as the display, and its outputs feed the mode/pattern control logic.

## Interface
- ROW_CYC, 4: clock cycles each row is driven. Must be ≥ 3.
- DEB_FRAMES, 2: consecutive identical frames needed to accept a press or a release. Must be ≥ 1.
- clk  in  1  1 kHz scan clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lie  in  4  matrix columns, active-low, pulled up externally, asynchronous to clk.
- hang  out  4  matrix row drive, active-low one-hot.
- key_code  out  4  last accepted key, computed as row*4 + column index (lie[0] = column 0). Held until the next accept.
- key_valid  out  1  one-cycle pulse when a key is accepted.
- key_down  out  1  high from accept until the release is debounced.

## Operation
- Synchronizer: lie passes through a 2-flop synchronizer to give lie_s. Inverted lie_s is the raw column vector, 1 = pressed.
- Scan counter: row index r (2 bits) and dwell counter d (0..ROW_CYC-1).
  - hang = ~(1<<r).
  - d increments each cycle. At d = ROW_CYC-1, d returns to 0 and r increments, wrapping from 3 to 0.
- Sampling: on the d = ROW_CYC-1 cycle, the inverted lie_s is written into snap[4r+3:4r]. This gives two cycles of settle plus synchronizer margin.
- Frame end: the cycle with r = 3 and d = ROW_CYC-1. The completed 16-bit frame is snap with row 3 included. It is compared against the previous frame, prev, and then copied into prev.
- A frame is single when it has exactly one bit set. It is empty when it is all zero.
- State machine, evaluated only at frame end:
  - IDLE:
    - Frame single and equal to prev: cnt++. Frame single and not equal to prev: cnt = 1. Any other frame: cnt = 0.
    - When cnt reaches DEB_FRAMES: load key_code with the index of the set bit, pulse key_valid, set key_down, clear cnt, go to PRESSED.
  - PRESSED:
    - Frame empty: cnt++. Any other frame (same key, other key, multiple keys): cnt = 0.
    - When cnt reaches DEB_FRAMES: clear key_down, clear cnt, go to IDLE.
- Rollover and multi-key:
  - Two or more keys in IDLE never produce an accept.
  - A second key pressed while in PRESSED is not reported. All keys must be released before a new accept.
- Width rules:
  - cnt is $clog2(DEB_FRAMES+1) bits and saturates at DEB_FRAMES.
  - d is $clog2(ROW_CYC) bits.

## Timing
- Reset values:
  - hang = 4'b1111, with no row driven while rst_n is low.
  - key_code = 0, key_valid = 0, key_down = 0.
  - state = IDLE; r, d, cnt = 0; snap and prev = 0.
- First clock after reset release: hang = 4'b1110.
- Frame period is 4*ROW_CYC cycles (16 cycles = 16 ms at the defaults).
- Outputs are registered. key_valid, key_code and key_down all change on the cycle after the frame-end edge that satisfies the condition. key_valid is high for exactly one cycle.
- Accept latency: for a key that is stable before a frame starts, the accept comes at the end of the DEB_FRAMES-th frame, plus 1 cycle.
- A press that appears partway through a frame makes that frame's sample row-dependent. That frame may count as 0 or 1 toward the debounce.
- Reset asserted mid-frame or in PRESSED: all outputs go immediately to their reset values. No key_valid is emitted on recovery unless the key is held through DEB_FRAMES fresh frames.

## Test plan
- Reset and scan:
  - Stimulus: hold rst_n low, then release; lie = 4'hF.
  - Required: hang = 4'b1111 during reset, then 1110, 1101, 1011, 0111, each for 4 cycles, repeating. key_valid is never asserted.
- Single press:
  - Stimulus: lie[2] = 0 whenever hang = 4'b1101 (row 1), held for 5 frames.
  - Required: exactly one key_valid pulse, with key_code = 6, and key_down = 1.
  - Release: key_down falls 2 frames (+1 cycle) after release.
- Bounce:
  - Stimulus: key 9 (row 2, column 1) toggles every 8 cycles for 3 frames, then is held.
  - Required: no accept during bouncing. One key_valid with key_code = 9 at the end of the 2nd stable frame.
- Multi-key:
  - Stimulus: keys 0 and 15 held together for 6 frames.
  - Required: no key_valid.
  - Follow-up: key 0 held alone. One accept with key_code = 0.
- Rollover:
  - Stimulus: key 3 accepted, then key 12 pressed while key 3 is still held, then key 3 released.
  - Required: no second key_valid until all keys are released for 2 frames and key 12 is then held alone for 2 frames.
- Reset mid-press:
  - Stimulus: assert rst_n low while key_down = 1, with key 5 still held.
  - Required: outputs are 0 immediately. After reset release, one new accept with key_code = 5 after 2 full frames.

Source files
------------

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner: drives rows low one at a time, samples the active-low
// columns, debounces whole-matrix frames and reports single key presses.
module key_matrix_scan #(
  parameter int ROW_CYC    = 4,
  parameter int DEB_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] lie,
  output logic [3:0] hang,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  // state   | meaning
  // IDLE    | waiting for DEB_FRAMES identical single-key frames
  // PRESSED | key reported, waiting for DEB_FRAMES empty frames
  typedef enum logic {IDLE, PRESSED} state_t;

  localparam int DW = $clog2(ROW_CYC);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(ROW_CYC - 1);
  localparam logic [CW-1:0] C_TGT  = CW'(DEB_FRAMES);

  state_t        state;
  logic [3:0]    lie_m, lie_s;
  logic [1:0]    r, r_nxt;
  logic [DW-1:0] d;
  logic [CW-1:0] cnt, cnt_inc, cnt_idle, cnt_pr;
  logic [15:0]   snap, prev, frame;
  logic [3:0]    cols, idx;
  logic [4:0]    ones;
  logic          row_last, frame_end, single, empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lie_m <= 4'hF;
      lie_s <= 4'hF;
    end else begin
      lie_m <= lie;
      lie_s <= lie_m;
    end
  end

  always_comb begin
    cols      = ~lie_s;
    row_last  = (d == D_LAST);
    frame_end = row_last && (r == 2'd3);
    r_nxt     = row_last ? r + 2'd1 : r;
    frame     = {cols, snap[11:0]};
    ones      = '0;
    idx       = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
    single   = (ones == 5'd1);
    empty    = (frame == 16'h0000);
    cnt_inc  = (cnt == C_TGT) ? cnt : cnt + CW'(1);
    cnt_idle = single ? ((frame == prev) ? cnt_inc : CW'(1)) : '0;
    cnt_pr   = empty ? cnt_inc : '0;
  end

  // hang tracks the row about to be active so the drive lines up with r
  // from the first clock after reset, giving each row its full settle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
      snap      <= '0;
      prev      <= '0;
      hang      <= 4'hF;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      hang      <= ~(4'b0001 << r_nxt);
      r         <= r_nxt;
      d         <= row_last ? '0 : d + DW'(1);
      if (row_last)
        snap[{r, 2'b00} +: 4] <= cols;
      if (frame_end) begin
        prev <= frame;
        case (state)
          IDLE: begin
            if (cnt_idle == C_TGT) begin
              key_code  <= idx;
              key_valid <= 1'b1;
              key_down  <= 1'b1;
              cnt       <= '0;
              state     <= PRESSED;
            end else begin
              cnt <= cnt_idle;
            end
          end
          PRESSED: begin
            if (cnt_pr == C_TGT) begin
              key_down <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt_pr;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a physical matrix model turns a pressed-key mask
// into column levels, and a frame-history model predicts every output cycle.
module tb_key_matrix_scan;
  localparam int ROW_CYC = 4;
  localparam int DEB     = 2;
  localparam int FR      = 4 * ROW_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  lie, hang, key_code;
  logic        key_valid, key_down;
  logic [15:0] pressed = '0;

  always #5 clk = ~clk;

  // a pressed key shorts its row line onto its column line
  always_comb begin
    lie = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        if (!hang[rr] && pressed[4*rr+c]) lie[c] = 1'b0;
  end

  key_matrix_scan #(.ROW_CYC(ROW_CYC), .DEB_FRAMES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .lie(lie), .hang(hang),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          p0;
  logic [15:0] hist [4];
  logic [15:0] cur_frame;
  logic [15:0] frames [$];
  bit          m_idle, m_valid, m_down;
  logic [3:0]  m_code;
  logic [15:0] mask;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int popc(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += v[i];
    return n;
  endfunction

  function automatic logic [3:0] key_of(input logic [15:0] v);
    logic [3:0] k = '0;
    for (int i = 0; i < 16; i++) if (v[i]) k = 4'(i);
    return k;
  endfunction

  task automatic model_reset();
    cyc = 0;
    frames = {};
    repeat (DEB) frames.push_back(16'h0);
    m_idle = 1; m_valid = 0; m_down = 0; m_code = '0;
    cur_frame = '0;
  endtask

  // decisions look only at the last DEB complete frames
  task automatic model_frame(input logic [15:0] f);
    bit ok;
    frames.push_back(f);
    if (frames.size() > 8) void'(frames.pop_front());
    if (m_idle) begin
      ok = (popc(f) == 1);
      for (int i = 1; i < DEB; i++) ok &= (frames[frames.size()-1-i] == f);
      if (ok) begin
        m_valid = 1; m_down = 1; m_code = key_of(f); m_idle = 0;
      end
    end else begin
      ok = 1;
      for (int i = 0; i < DEB; i++) ok &= (frames[frames.size()-1-i] == 16'h0);
      if (ok) begin
        m_down = 0; m_idle = 1;
      end
    end
  endtask

  task automatic step();
    int rr;
    logic [3:0] eh;
    @(posedge clk);
    cyc++;
    hist[cyc % 4] = pressed;
    m_valid = 0;
    if (cyc % ROW_CYC == 0) begin
      rr = ((cyc % FR) / ROW_CYC + 3) % 4;
      cur_frame[4*rr +: 4] = hist[(cyc + 2) % 4][4*rr +: 4];
      if (cyc % FR == 0) model_frame(cur_frame);
    end
    #1;
    eh = ~(4'b0001 << ((cyc / ROW_CYC) % 4));
    chk("hang", 16'(hang), 16'(eh));
    chk("key_valid", 16'(key_valid), 16'(m_valid));
    chk("key_down", 16'(key_down), 16'(m_down));
    chk("key_code", 16'(key_code), 16'(m_code));
    if (key_valid) pulses++;
  endtask

  task automatic run(input int n, input logic [15:0] m);
    pressed = m;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_hang", 16'(hang), 16'hF);
    chk("rst_valid", 16'(key_valid), 16'h0);
    chk("rst_down", 16'(key_down), 16'h0);
    chk("rst_code", 16'(key_code), 16'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hang_hold", 16'(hang), 16'hF);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // idle scanning
    p0 = pulses;
    run(2*FR, 16'h0);
    chk("scan_no_valid", 16'(pulses - p0), 16'd0);

    // single press of key 6, then release
    p0 = pulses;
    run(5*FR, 16'h0040);
    chk("single_pulses", 16'(pulses - p0), 16'd1);
    chk("single_code", 16'(key_code), 16'd6);
    chk("single_down", 16'(key_down), 16'd1);
    run(2*FR, 16'h0);
    chk("release_down", 16'(key_down), 16'd0);

    // key 9 bouncing, then held
    p0 = pulses;
    repeat (3) begin
      run(8, 16'h0200);
      run(8, 16'h0);
    end
    chk("bounce_none", 16'(pulses - p0), 16'd0);
    run(2*FR, 16'h0200);
    chk("bounce_pulse", 16'(pulses - p0), 16'd1);
    chk("bounce_code", 16'(key_code), 16'd9);
    run(3*FR, 16'h0);

    // keys 0 and 15 together, then 0 alone
    p0 = pulses;
    run(6*FR, 16'h8001);
    chk("multi_none", 16'(pulses - p0), 16'd0);
    run(3*FR, 16'h0001);
    chk("multi_follow", 16'(pulses - p0), 16'd1);
    chk("multi_code", 16'(key_code), 16'd0);
    run(3*FR, 16'h0);

    // rollover 3 -> 3+12 -> 12, release, then 12 alone
    p0 = pulses;
    run(3*FR, 16'h0008);
    run(3*FR, 16'h1008);
    run(3*FR, 16'h1000);
    chk("roll_one", 16'(pulses - p0), 16'd1);
    chk("roll_code3", 16'(key_code), 16'd3);
    run(2*FR, 16'h0);
    run(2*FR, 16'h1000);
    chk("roll_two", 16'(pulses - p0), 16'd2);
    chk("roll_code12", 16'(key_code), 16'd12);
    run(3*FR, 16'h0);

    // random masks with unaligned durations
    mask = '0;
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: mask = 16'h0;
        1: mask = 16'h1 << $urandom_range(0, 15);
        2: mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: ;
      endcase
      run($urandom_range(4, 48), mask);
    end
    run(3*FR, 16'h0);

    // reset while key 5 is down
    run(3*FR, 16'h0020);
    chk("pre_reset_down", 16'(key_down), 16'd1);
    run(5, 16'h0020);
    do_reset();
    p0 = pulses;
    run(2*FR, 16'h0020);
    chk("post_reset_pulse", 16'(pulses - p0), 16'd1);
    chk("post_reset_code", 16'(key_code), 16'd5);
    run(FR, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
